// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: FSM state and termination encodings, bus widths.
// Used by the slave memory, the master model and the bridge.
package wb_pkg;

    localparam int WORD_W = 32;
    localparam int LANE_W = 8;
    localparam int LANES  = WORD_W / LANE_W;
    localparam int TAG_W  = 4;
    localparam int WS_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        TERM_ACK = 2'd0,
        TERM_ERR = 2'd1,
        TERM_RTY = 2'd2
    } term_e;

endpackage

// File: rtl/wb_slave_ram.sv
// Word RAM with per-lane synchronous write and registered read.
// One-cycle read latency; read register holds until the next read enable, no backpressure.
module wb_slave_ram
    import wb_pkg::*;
#(
    parameter int WORDS = 256,
    parameter int IW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic              i_core_clk,
    input  logic              i_arst_n,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [IW-1:0]     i_addr,
    input  logic [LANES-1:0]  i_be,
    input  logic [WORD_W-1:0] i_wdat,
    output logic [WORD_W-1:0] o_rdat
);

    logic [WORD_W-1:0] r_mem [WORDS];
    logic [WORD_W-1:0] r_rdat;

    // Array contents are deliberately left out of reset.
    always_ff @(posedge i_core_clk) begin
        if (i_we) begin
            for (int b = 0; b < LANES; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][b*LANE_W +: LANE_W] <= i_wdat[b*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_ff @(posedge i_core_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_rdat <= '0;
        end else if (i_re) begin
            r_rdat <= r_mem[i_addr];
        end
    end

    assign o_rdat = r_rdat;

endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone classic slave over a word RAM with programmable wait states and ERR/RTY injection.
// Termination WS_I+1 clocks after accept; master holds STB_I until terminated, dropping it aborts.
module wb_slave_mem
    import wb_pkg::*;
#(
    parameter int AW          = 16,
    parameter int MEM_WORDS   = 256,
    parameter int RETRY_EVERY = 0
) (
    input  logic              CLK_I,
    input  logic              RSTN_I,
    input  logic              CYC_I,
    input  logic              STB_I,
    input  logic              WE_I,
    input  logic [AW-1:0]     ADR_I,
    input  logic [LANES-1:0]  SEL_I,
    input  logic [WORD_W-1:0] DAT_I,
    input  logic [TAG_W-1:0]  TAG_I,
    input  logic [WS_W-1:0]   WS_I,
    output logic [WORD_W-1:0] DAT_O,
    output logic              ACK_O,
    output logic              ERR_O,
    output logic              RTY_O,
    output logic [TAG_W-1:0]  TAG_O
);

    localparam int IW  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int RCW = (RETRY_EVERY > 1) ? $clog2(RETRY_EVERY) : 1;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [WS_W-1:0]   r_wcnt;
    logic [RCW-1:0]    r_rcnt;

    logic              r_we;
    logic [AW-3:0]     r_idx;
    logic [LANES-1:0]  r_sel;
    logic [WORD_W-1:0] r_dat;
    logic [TAG_W-1:0]  r_tag;

    logic              r_ack;
    logic              r_err;
    logic              r_rty;
    logic [TAG_W-1:0]  r_tag_o;

    logic              w_req;
    logic              w_idle;
    logic              w_we;
    logic [AW-3:0]     w_idx;
    logic [LANES-1:0]  w_sel;
    logic [WORD_W-1:0] w_dat;
    logic [TAG_W-1:0]  w_tag;
    logic              w_oob;
    logic              w_rty_hit;
    logic              w_rcnt_wrap;
    logic              w_enter_resp;
    term_e             w_term;
    logic              w_unused_adr;

    assign w_req  = CYC_I & STB_I;
    assign w_idle = (r_state == ST_IDLE);

    // With zero wait states RESP is entered on the accept edge itself, so use the live request.
    assign w_we  = w_idle ? WE_I         : r_we;
    assign w_idx = w_idle ? ADR_I[AW-1:2] : r_idx;
    assign w_sel = w_idle ? SEL_I        : r_sel;
    assign w_dat = w_idle ? DAT_I        : r_dat;
    assign w_tag = w_idle ? TAG_I        : r_tag;

    assign w_unused_adr = &{1'b0, ADR_I[1:0]};

    assign w_oob        = 32'(w_idx) >= 32'(MEM_WORDS);
    assign w_rcnt_wrap  = (r_rcnt == RCW'(RETRY_EVERY - 1));
    assign w_rty_hit    = (RETRY_EVERY > 0) && w_rcnt_wrap;
    assign w_enter_resp = (w_state_nxt == ST_RESP);

    always_comb begin
        w_term = TERM_ACK;
        if (w_oob) begin
            w_term = TERM_ERR;
        end else if (w_rty_hit) begin
            w_term = TERM_RTY;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_state_nxt = (WS_I == '0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!w_req) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_wcnt == WS_W'(1)) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            r_state <= ST_IDLE;
            r_wcnt  <= '0;
            r_rcnt  <= '0;
            r_we    <= 1'b0;
            r_idx   <= '0;
            r_sel   <= '0;
            r_dat   <= '0;
            r_tag   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rty   <= 1'b0;
            r_tag_o <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_idle && w_req) begin
                r_wcnt <= WS_I;
                r_we   <= WE_I;
                r_idx  <= ADR_I[AW-1:2];
                r_sel  <= SEL_I;
                r_dat  <= DAT_I;
                r_tag  <= TAG_I;
            end else if (r_state == ST_WAIT) begin
                r_wcnt <= r_wcnt - 1'b1;
            end
            // Every completed (non-aborted) request advances the retry counter, ERR included.
            if (RETRY_EVERY > 0 && w_enter_resp) begin
                r_rcnt <= w_rcnt_wrap ? '0 : r_rcnt + RCW'(1);
            end
            r_ack <= w_enter_resp && (w_term == TERM_ACK);
            r_err <= w_enter_resp && (w_term == TERM_ERR);
            r_rty <= w_enter_resp && (w_term == TERM_RTY);
            if (w_enter_resp) begin
                r_tag_o <= w_tag;
            end
        end
    end

    wb_slave_ram #(
        .WORDS (MEM_WORDS),
        .IW    (IW)
    ) u_ram (
        .i_core_clk (CLK_I),
        .i_arst_n   (RSTN_I),
        .i_we       (w_enter_resp && (w_term == TERM_ACK) && w_we),
        .i_re       (w_enter_resp && (w_term == TERM_ACK) && !w_we),
        .i_addr     (w_idx[IW-1:0]),
        .i_be       (w_sel),
        .i_wdat     (w_dat),
        .o_rdat     (DAT_O)
    );

    assign ACK_O = r_ack;
    assign ERR_O = r_err;
    assign RTY_O = r_rty;
    assign TAG_O = r_tag_o;

endmodule

// File: tb/tb_wb_slave_mem.sv
// Directed bench for wb_slave_mem with RETRY_EVERY=3 and 256 words.
module tb_wb_slave_mem;

    localparam logic [2:0] T_NONE = 3'b000;
    localparam logic [2:0] T_ACK  = 3'b001;
    localparam logic [2:0] T_ERR  = 3'b010;
    localparam logic [2:0] T_RTY  = 3'b100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc_i, stb_i, we_i;
    logic [15:0] adr_i;
    logic [3:0]  sel_i;
    logic [31:0] dat_i;
    logic [3:0]  tag_i;
    logic [3:0]  ws_i;
    logic [31:0] dat_o;
    logic        ack_o, err_o, rty_o;
    logic [3:0]  tag_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_slave_mem #(
        .AW          (16),
        .MEM_WORDS   (256),
        .RETRY_EVERY (3)
    ) u_dut (
        .CLK_I  (clk),
        .RSTN_I (rst_n),
        .CYC_I  (cyc_i),
        .STB_I  (stb_i),
        .WE_I   (we_i),
        .ADR_I  (adr_i),
        .SEL_I  (sel_i),
        .DAT_I  (dat_i),
        .TAG_I  (tag_i),
        .WS_I   (ws_i),
        .DAT_O  (dat_o),
        .ACK_O  (ack_o),
        .ERR_O  (err_o),
        .RTY_O  (rty_o),
        .TAG_O  (tag_o)
    );

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    // One request: drive at a falling edge, scramble inputs after accept, wait for termination.
    task automatic bus(input string nm, input logic we, input logic [15:0] adr,
                       input logic [3:0] sel, input logic [31:0] dat, input logic [3:0] tag,
                       input logic [3:0] ws, input logic [2:0] exp_term,
                       input logic [31:0] exp_dat, input logic keep);
        int lat;
        logic [2:0] term;
        @(negedge clk);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr;
        sel_i = sel;  dat_i = dat;  tag_i = tag; ws_i = ws;
        @(negedge clk);
        we_i = ~we; adr_i = ~adr; sel_i = ~sel; dat_i = ~dat; tag_i = ~tag; ws_i = ~ws;
        lat  = 1;
        term = {rty_o, err_o, ack_o};
        while (term == T_NONE && lat < 32) begin
            @(negedge clk);
            lat++;
            term = {rty_o, err_o, ack_o};
        end
        chk({nm, "_term"}, 32'(term), 32'(exp_term));
        chk({nm, "_lat"},  32'(lat),  32'(ws) + 32'd1);
        chk({nm, "_tag"},  32'(tag_o), 32'(tag));
        chk({nm, "_dat"},  dat_o, exp_dat);
        stb_i = 1'b0;
        if (!keep) cyc_i = 1'b0;
        @(negedge clk);
        chk({nm, "_1cyc"}, 32'({rty_o, err_o, ack_o}), 32'(T_NONE));
    endtask

    initial begin
        logic [2:0] seen;
        rst_n = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; adr_i = '0;
        sel_i = '0;   dat_i = '0;   tag_i = '0;   ws_i = '0;
        #12;
        chk("rst_ack", 32'(ack_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_rty", 32'(rty_o), 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_tag", 32'(tag_o), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Retry counter starts at 0: accepts 3,6,9,... answer RTY unless out of range.
        bus("k1_wr10",   1, 16'h0010, 4'hF, 32'hDEADBEEF, 4'h1, 4'd0, T_ACK, 32'h00000000, 0);
        bus("k2_rd13",   0, 16'h0013, 4'hF, 32'h0,        4'h2, 4'd0, T_ACK, 32'hDEADBEEF, 0);
        bus("k3_wr20",   1, 16'h0020, 4'hF, 32'hFFFFFFFF, 4'h3, 4'd0, T_RTY, 32'hDEADBEEF, 0);
        bus("k4_wr20",   1, 16'h0020, 4'hF, 32'hFFFFFFFF, 4'h4, 4'd0, T_ACK, 32'hDEADBEEF, 0);
        bus("k5_wr20b0", 1, 16'h0020, 4'h1, 32'h11223344, 4'h5, 4'd0, T_ACK, 32'hDEADBEEF, 0);
        bus("k6_rd20",   0, 16'h0020, 4'hF, 32'h0,        4'h6, 4'd0, T_RTY, 32'hDEADBEEF, 0);
        bus("k7_rd20",   0, 16'h0020, 4'hF, 32'h0,        4'h7, 4'd0, T_ACK, 32'hFFFFFF44, 0);
        bus("k8_wr04",   1, 16'h0004, 4'hF, 32'hCAFEF00D, 4'h8, 4'd0, T_ACK, 32'hFFFFFF44, 0);
        bus("k9_rd10",   0, 16'h0010, 4'hF, 32'h0,        4'h9, 4'd0, T_RTY, 32'hFFFFFF44, 0);
        bus("k10_rd04w3",0, 16'h0004, 4'hF, 32'h0,        4'hA, 4'd3, T_ACK, 32'hCAFEF00D, 0);

        // Aborted write: STB dropped in the second cycle of WAIT.
        @(negedge clk);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 16'h0004;
        sel_i = 4'hF; dat_i = 32'h12345678; tag_i = 4'hB; ws_i = 4'd3;
        @(negedge clk);
        @(negedge clk);
        stb_i = 1'b0; cyc_i = 1'b0;
        seen = T_NONE;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen = seen | {rty_o, err_o, ack_o};
        end
        chk("abort_noterm", 32'(seen), 32'(T_NONE));

        bus("k11_wr00",  1, 16'h0000, 4'hF, 32'h01020304, 4'hC, 4'd0, T_ACK, 32'hCAFEF00D, 0);
        bus("k12_wr400", 1, 16'h0400, 4'hF, 32'hAAAAAAAA, 4'hD, 4'd0, T_ERR, 32'hCAFEF00D, 0);
        bus("k13_rd00",  0, 16'h0000, 4'hF, 32'h0,        4'hE, 4'd0, T_ACK, 32'h01020304, 0);
        bus("k14_rd04",  0, 16'h0004, 4'hF, 32'h0,        4'hF, 4'd0, T_ACK, 32'hCAFEF00D, 0);
        bus("k15_rd04",  0, 16'h0004, 4'hF, 32'h0,        4'h0, 4'd0, T_RTY, 32'hCAFEF00D, 0);
        bus("k16_wr08",  1, 16'h0008, 4'hF, 32'h00000005, 4'h1, 4'd0, T_ACK, 32'hCAFEF00D, 0);

        // Reset asserted while a write sits in WAIT.
        @(negedge clk);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 16'h0008;
        sel_i = 4'hF; dat_i = 32'h00000077; tag_i = 4'h6; ws_i = 4'd3;
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("wrst_ack", 32'(ack_o), 32'd0);
        chk("wrst_err", 32'(err_o), 32'd0);
        chk("wrst_rty", 32'(rty_o), 32'd0);
        chk("wrst_dat", dat_o, 32'd0);
        chk("wrst_tag", 32'(tag_o), 32'd0);
        @(negedge clk); cyc_i = 1'b0; stb_i = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        // RMW inside one CYC: old data first, then the update is visible.
        bus("j1_rmw_rd", 0, 16'h0008, 4'hF, 32'h0,        4'h2, 4'd0, T_ACK, 32'h00000005, 1);
        bus("j2_rmw_wr", 1, 16'h0008, 4'hF, 32'h0000000A, 4'h3, 4'd0, T_ACK, 32'h00000005, 0);
        bus("j3_rd08",   0, 16'h0008, 4'hF, 32'h0,        4'h4, 4'd0, T_RTY, 32'h00000005, 0);
        bus("j4_rd08",   0, 16'h0008, 4'hF, 32'h0,        4'h5, 4'd0, T_ACK, 32'h0000000A, 0);

        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        // Six back-to-back reads in one CYC: ACK,ACK,RTY,ACK,ACK,RTY.
        bus("r1", 0, 16'h0008, 4'hF, 32'h0, 4'h1, 4'd0, T_ACK, 32'h0000000A, 1);
        bus("r2", 0, 16'h0010, 4'hF, 32'h0, 4'h2, 4'd0, T_ACK, 32'hDEADBEEF, 1);
        bus("r3", 0, 16'h0008, 4'hF, 32'h0, 4'h3, 4'd0, T_RTY, 32'hDEADBEEF, 1);
        bus("r4", 0, 16'h0008, 4'hF, 32'h0, 4'h4, 4'd0, T_ACK, 32'h0000000A, 1);
        bus("r5", 0, 16'h0010, 4'hF, 32'h0, 4'h5, 4'd0, T_ACK, 32'hDEADBEEF, 1);
        bus("r6", 0, 16'h0008, 4'hF, 32'h0, 4'h6, 4'd0, T_RTY, 32'hDEADBEEF, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
